stream_serializer: RTL and testbench

//   Transmit side of the valid/ready byte stream: accepts one wide result word
//   (e.g. a 32-bit matmul accumulator) per handshake and emits it as
//   W_IN/W_OUT narrow beats on a valid/ready output toward the 8-bit pad

---
 rtl/stream_serializer_pkg.sv | 22 ++
 rtl/stream_serializer.sv | 101 ++++++++++
 tb/tb_stream_serializer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_serializer_pkg.sv
// Shared types and sizing helpers for the stream serializer.
// Beat count and counter width are derived here so the top stays generic.
package stream_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SEND = 1'b1;

    typedef enum logic {
        IDLE = ST_IDLE,
        SEND = ST_SEND
    } ser_state_e;

    function automatic int beats(input int w_in, input int w_out);
        return w_in / w_out;
    endfunction

    // A one-beat word still needs a 1-bit counter to keep ports legal.
    function automatic int cnt_width(input int n_beats);
        return (n_beats <= 1) ? 1 : $clog2(n_beats);
    endfunction

endpackage

// File: rtl/stream_serializer.sv
// Wide-to-narrow valid/ready serializer: one W_IN word in, BEATS beats out.
// Next word loads on the final-beat handshake so beats run back to back.
module stream_serializer
    import stream_pkg::*;
#(
    parameter int W_IN      = 32,
    parameter int W_OUT     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W_IN-1:0]  s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W_OUT-1:0] m_data,
    output logic             m_last
);

    localparam int BEATS = beats(W_IN, W_OUT);
    localparam int CW    = cnt_width(BEATS);

    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
    localparam logic [CW-1:0] PRE_CNT  = CW'(BEATS - 2);

    if (W_IN % W_OUT != 0) begin : g_bad_width
        $error("stream_serializer: W_IN must be a multiple of W_OUT");
    end

    ser_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [W_IN-1:0]  shreg_q;
    logic [W_IN-1:0]  shreg_d;
    logic             held_last_q;
    logic             m_valid_q;
    logic             m_last_q;
    logic             at_last;

    assign at_last = (cnt_q == LAST_CNT);

    assign s_ready = rstn &&
                     ((state_q == IDLE) || (at_last && m_ready));

    assign shreg_d = MSB_FIRST ? (shreg_q << W_OUT)
                               : (shreg_q >> W_OUT);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            held_last_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (s_valid) begin
                        state_q     <= SEND;
                        cnt_q       <= '0;
                        shreg_q     <= s_data;
                        held_last_q <= s_last;
                        m_valid_q   <= 1'b1;
                        m_last_q    <= (BEATS == 1) ? s_last : 1'b0;
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        if (!at_last) begin
                            cnt_q    <= cnt_q + CW'(1);
                            shreg_q  <= shreg_d;
                            m_last_q <= held_last_q && (cnt_q == PRE_CNT);
                        end else if (s_valid) begin
                            cnt_q       <= '0;
                            shreg_q     <= s_data;
                            held_last_q <= s_last;
                            m_last_q    <= (BEATS == 1) ? s_last : 1'b0;
                        end else begin
                            state_q   <= IDLE;
                            cnt_q     <= '0;
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;

    if (MSB_FIRST) begin : g_msb
        assign m_data = shreg_q[W_IN-1 -: W_OUT];
    end else begin : g_lsb
        assign m_data = shreg_q[W_OUT-1:0];
    end

endmodule

// File: tb/tb_stream_serializer.sv
// Bench for stream_serializer: LSB-first and MSB-first instances share stimulus.
// A beat-queue model predicts outputs every cycle; directed cases pin literals.
module tb_stream_serializer;

    logic        clk;
    logic        rstn;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        m_ready;

    logic        s_ready_l, m_valid_l, m_last_l;
    logic [7:0]  m_data_l;
    logic        s_ready_m, m_valid_m, m_last_m;
    logic [7:0]  m_data_m;

    int errs;
    int checks;
    int cyc;
    int mode;

    logic [8:0] ql[$];
    logic [8:0] qm[$];
    logic [8:0] log_l[$];
    logic [8:0] log_m[$];
    int         log_cyc[$];
    int         acc_cyc[$];

    stream_serializer #(.W_IN(32), .W_OUT(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready_l),
        .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid_l), .m_ready(m_ready),
        .m_data(m_data_l), .m_last(m_last_l)
    );

    stream_serializer #(.W_IN(32), .W_OUT(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready_m),
        .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid_m), .m_ready(m_ready),
        .m_data(m_data_m), .m_last(m_last_m)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Model: each accepted word becomes four pending beats per instance.
    initial begin
        logic       exp_rdy, exp_vld, hs_m, hs_s, rst_seen, lst;
        logic [31:0] w;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_vld = (ql.size() != 0);
            exp_rdy = rstn && (ql.size() == 0 ||
                               (ql.size() == 1 && m_ready));
            chk("s_ready_lsb", s_ready_l, exp_rdy);
            chk("s_ready_msb", s_ready_m, exp_rdy);
            chk("m_valid_lsb", m_valid_l, exp_vld);
            chk("m_valid_msb", m_valid_m, exp_vld);
            if (exp_vld) begin
                chk("m_data_lsb", m_data_l, ql[0][7:0]);
                chk("m_last_lsb", m_last_l, ql[0][8]);
                chk("m_data_msb", m_data_m, qm[0][7:0]);
                chk("m_last_msb", m_last_m, qm[0][8]);
            end
            rst_seen = !rstn;
            hs_m = exp_vld && m_ready;
            hs_s = exp_rdy && s_valid;
            w    = s_data;
            lst  = s_last;
            @(posedge clk);
            cyc++;
            if (rst_seen) begin
                ql.delete();
                qm.delete();
            end else begin
                if (hs_m) begin
                    log_l.push_back(ql.pop_front());
                    log_m.push_back(qm.pop_front());
                    log_cyc.push_back(cyc);
                end
                if (hs_s) begin
                    acc_cyc.push_back(cyc);
                    for (int i = 0; i < 4; i++) begin
                        ql.push_back({lst && i == 3, w[8*i +: 8]});
                        qm.push_back({lst && i == 3, w[8*(3-i) +: 8]});
                    end
                end
            end
        end
    end

    initial begin
        int k;
        k = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                1:       m_ready = (k % 3 == 0);
                2:       m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = 1'b1;
            endcase
            k++;
        end
    end

    task automatic clear_logs();
        log_l.delete();
        log_m.delete();
        log_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic send_word(input logic [31:0] w, input logic lst);
        logic hs;
        int   n;
        s_valid = 1'b1;
        s_data  = w;
        s_last  = lst;
        n = 0;
        do begin
            @(negedge clk);
            hs = s_ready_l;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 200);
        if (!hs) chk("send_timeout", 32'(n), 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (ql.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (ql.size() != 0) chk("drain_timeout", 32'(ql.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string nm, input bit msb, input int base,
                        input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3,
                        input logic lst);
        logic [8:0] e[4];
        int sz;
        e[0] = {1'b0, b0};
        e[1] = {1'b0, b1};
        e[2] = {1'b0, b2};
        e[3] = {lst, b3};
        sz = msb ? log_m.size() : log_l.size();
        chk({nm, "_count"}, 32'(sz >= base + 4), 32'd1);
        if (sz >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("%s_beat%0d", nm, i),
                    msb ? log_m[base+i] : log_l[base+i], e[i]);
            end
        end
    endtask

    initial begin
        int n;
        errs    = 0;
        checks  = 0;
        cyc     = 0;
        mode    = 0;
        rstn    = 1'b0;
        s_valid = 1'b0;
        s_data  = 32'h0;
        s_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("reset_m_valid", m_valid_l, 1'b0);
        chk("reset_m_data", m_data_l, 8'h00);
        chk("reset_m_last", m_last_l, 1'b0);
        chk("reset_s_ready", s_ready_l, 1'b1);
        @(posedge clk);
        #1;

        // single word, LSB first
        clear_logs();
        send_word(32'hDDCCBBAA, 1'b1);
        s_valid = 1'b0;
        drain();
        chk4("t1_lsb", 1'b0, 0, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 1'b1);
        chk4("t1_msb", 1'b1, 0, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 1'b1);
        if (log_cyc.size() >= 4 && acc_cyc.size() >= 1) begin
            chk("t1_first_latency", 32'(log_cyc[0] - acc_cyc[0]), 32'd1);
            chk("t1_span", 32'(log_cyc[3] - log_cyc[0]), 32'd3);
        end

        // back-to-back words
        clear_logs();
        send_word(32'h04030201, 1'b0);
        send_word(32'h08070605, 1'b1);
        s_valid = 1'b0;
        drain();
        chk4("t2_w0", 1'b0, 0, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
        chk4("t2_w1", 1'b0, 4, 8'h05, 8'h06, 8'h07, 8'h08, 1'b1);
        if (log_cyc.size() >= 8 && acc_cyc.size() >= 2) begin
            chk("t2_no_bubble", 32'(log_cyc[7] - log_cyc[0]), 32'd7);
            chk("t2_accept_edge", 32'(acc_cyc[1]), 32'(log_cyc[3]));
        end

        // m_ready toggling
        clear_logs();
        mode = 1;
        send_word(32'h11223344, 1'b0);
        s_valid = 1'b0;
        drain();
        mode = 0;
        chk4("t3", 1'b0, 0, 8'h44, 8'h33, 8'h22, 8'h11, 1'b0);
        chk("t3_no_dup", 32'(log_l.size()), 32'd4);

        // MSB-first order
        clear_logs();
        send_word(32'hA1B2C3D4, 1'b1);
        s_valid = 1'b0;
        drain();
        chk4("t4_msb", 1'b1, 0, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b1);

        // reset mid-word
        clear_logs();
        send_word(32'hCAFEBABE, 1'b0);
        s_valid = 1'b0;
        n = 0;
        while (log_l.size() < 2 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t5_two_beats", 32'(log_l.size()), 32'd2);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("t5_valid_after_rst", m_valid_l, 1'b0);
        @(posedge clk);
        #1;
        clear_logs();
        send_word(32'h00000055, 1'b1);
        s_valid = 1'b0;
        drain();
        chk4("t5_clean", 1'b0, 0, 8'h55, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("t5_count", 32'(log_l.size()), 32'd4);

        // random traffic against the model
        clear_logs();
        mode = 2;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_word($urandom, 1'($urandom_range(0, 1)));
        end
        s_valid = 1'b0;
        drain();
        mode = 0;
        chk("t6_beat_total", 32'(log_l.size()), 32'd8000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
